// File: rtl/branch_predict_bht.sv
// Branch history table predictor: a table of saturating counters indexed
// either by the fetch PC (bimodal) or by the PC XOR a global history
// register (gshare).  Lookup is purely combinational; the resolved-branch
// update port trains one counter per cycle and counts mispredictions.
module branch_predict_bht #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic [31:0]        inst,
  output logic               branch_predict,
  output logic [31:0]        branch_predict_addr,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [PERF_W-1:0]  mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;
  // Weakly-not-taken: one below the taken threshold (0 for 1-bit counters).
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]    r_cnt [ENTRIES];
  logic [PERF_W-1:0]   r_mis;
  logic [INDEX_W-1:0]  w_hist;
  logic [INDEX_W-1:0]  w_index;
  logic [5:0]          w_opcode;
  logic [4:0]          w_rt;
  logic                w_is_branch;
  logic signed [31:0]  w_offset;
  logic                w_unused;

  // Saturating up/down step of one pattern counter.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic up);
    if (up) return (cur == '1) ? cur : cur + CNT_W'(1);
    return (cur == '0) ? cur : cur - CNT_W'(1);
  endfunction

  // Saturating increment of the misprediction counter.
  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] cur);
    return (cur == '1) ? cur : cur + PERF_W'(1);
  endfunction

  assign w_opcode = inst[31:26];
  assign w_rt     = inst[20:16];
  // rs field does not influence prediction or target.
  assign w_unused = ^inst[25:21];

  // Decode conditional branches (I-type and REGIMM forms).
  always_comb begin
    w_is_branch = 1'b0;
    case (w_opcode)
      6'b000100, 6'b000101, 6'b000110, 6'b000111: w_is_branch = 1'b1;
      6'b000001: w_is_branch = (w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                               (w_rt == 5'b10000) || (w_rt == 5'b10001);
      default: w_is_branch = 1'b0;
    endcase
  end

  // Global history: absent in bimodal mode, shift register in gshare mode.
  generate
    if (GHR_W == 0) begin : g_bimodal
      assign w_hist = '0;
    end else begin : g_gshare
      logic [GHR_W-1:0] r_ghr;

      // Shift the newest resolved outcome into the LSB; truncation keeps
      // exactly GHR_W bits (degenerates to r_ghr <= upd_taken for 1 bit).
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_ghr <= '0;
        else if (upd_valid) r_ghr <= GHR_W'({r_ghr, upd_taken});
      end

      // Zero-extend the history to the index width.
      always_comb begin
        w_hist              = '0;
        w_hist[GHR_W-1:0]   = r_ghr;
      end
    end
  endgenerate

  assign w_index    = pc[INDEX_W+1:2] ^ w_hist;
  assign pred_index = w_index;

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign branch_predict = w_is_branch & r_cnt[w_index][CNT_W-1];

  assign w_offset            = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign branch_predict_addr = pc + 32'd4 + $unsigned(w_offset);

  // Train the addressed counter on each resolved branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    end else if (upd_valid) begin
      r_cnt[upd_index] <= cnt_step(r_cnt[upd_index], upd_taken);
    end
  end

  // Count mispredicted resolved branches, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_mis <= '0;
    else if (upd_valid && upd_mispredict) r_mis <= perf_inc(r_mis);
  end

  assign mispredict_cnt = r_mis;

endmodule

// File: tb/tb_branch_predict_bht.sv
// Bench for branch_predict_bht: a bimodal instance (defaults) and a gshare
// instance (GHR_W=4, PERF_W=2) share one stimulus stream.  A behavioural
// model of both tables is compared against every output on each falling
// edge, with directed literal checks for the worked examples.
module tb_branch_predict_bht;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        upd_valid;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        bp_b, bp_g;
  logic [31:0] addr_b, addr_g;
  logic [5:0]  idx_b, idx_g;
  logic [31:0] mis_b;
  logic [1:0]  mis_g;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural state: counters as plain ints, history as an int.
  int m_b [64];
  int m_g [64];
  int m_ghr;
  int m_mis_b;
  int m_mis_g;

  branch_predict_bht u_bim (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .branch_predict(bp_b), .branch_predict_addr(addr_b), .pred_index(idx_b),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(mis_b)
  );

  branch_predict_bht #(.GHR_W(4), .PERF_W(2)) u_gsh (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .branch_predict(bp_g), .branch_predict_addr(addr_g), .pred_index(idx_g),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(mis_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_branch(input logic [31:0] w);
    int op, rt;
    op = int'(w >> 26);
    rt = int'((w >> 16) & 32'h1F);
    if (op >= 4 && op <= 7) return 1'b1;
    if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
    return 1'b0;
  endfunction

  // Model state update: async reset, otherwise apply a resolved branch.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        m_b[i] <= 1;
        m_g[i] <= 1;
      end
      m_ghr   <= 0;
      m_mis_b <= 0;
      m_mis_g <= 0;
    end else if (upd_valid) begin
      m_b[upd_index] <= upd_taken ? ((m_b[upd_index] < 3) ? m_b[upd_index] + 1 : 3)
                                  : ((m_b[upd_index] > 0) ? m_b[upd_index] - 1 : 0);
      m_g[upd_index] <= upd_taken ? ((m_g[upd_index] < 3) ? m_g[upd_index] + 1 : 3)
                                  : ((m_g[upd_index] > 0) ? m_g[upd_index] - 1 : 0);
      m_ghr <= (m_ghr * 2 + (upd_taken ? 1 : 0)) % 16;
      if (upd_mispredict) begin
        m_mis_b <= m_mis_b + 1;
        m_mis_g <= (m_mis_g < 3) ? m_mis_g + 1 : 3;
      end
    end
  end

  // Compare every output of both instances against the model.
  always @(negedge clk) begin
    int ib, ig, imm;
    logic [31:0] ea;
    ib  = int'(pc / 4) % 64;
    ig  = ib ^ m_ghr;
    imm = int'($signed(inst[15:0]));
    ea  = pc + 32'(4 + imm * 4);
    check("bim_index", {26'd0, idx_b}, 32'(ib));
    check("gsh_index", {26'd0, idx_g}, 32'(ig));
    check("bim_pred", {31'd0, bp_b}, 32'(is_branch(inst) && m_b[ib] >= 2));
    check("gsh_pred", {31'd0, bp_g}, 32'(is_branch(inst) && m_g[ig] >= 2));
    check("bim_addr", addr_b, ea);
    check("gsh_addr", addr_g, ea);
    check("bim_miscnt", mis_b, 32'(m_mis_b));
    check("gsh_miscnt", {30'd0, mis_g}, 32'(m_mis_g));
  end

  // One update presented for exactly one rising edge.
  task automatic do_upd(input int idx, input bit tk, input bit mis);
    upd_valid      = 1'b1;
    upd_index      = 6'(idx);
    upd_taken      = tk;
    upd_mispredict = mis;
    @(posedge clk); #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  logic [31:0] br_ops [8];

  initial begin
    br_ops[0] = 32'h1000_0000; br_ops[1] = 32'h1400_0000;
    br_ops[2] = 32'h1800_0000; br_ops[3] = 32'h1C00_0000;
    br_ops[4] = 32'h0400_0000; br_ops[5] = 32'h0401_0000;
    br_ops[6] = 32'h0410_0000; br_ops[7] = 32'h0411_0000;

    rst = 1'b1; upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
    upd_mispredict = 1'b0;
    pc = 32'h0040_0000; inst = 32'h1000_0003;
    #1 rst = 1'b0;
    #1;
    // Reset state lookup.
    check("rst_pred", {31'd0, bp_b}, 32'd0);
    check("rst_addr", addr_b, 32'h0040_0010);
    check("rst_index", {26'd0, idx_b}, 32'd0);
    check("rst_miscnt", mis_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Train index 5 and observe the hysteresis.
    do_upd(5, 1'b1, 1'b0);
    do_upd(5, 1'b1, 1'b0);
    pc = 32'h0000_0014; inst = 32'h1000_0000; #1;
    check("idx5_2taken", {31'd0, bp_b}, 32'd1);
    do_upd(5, 1'b1, 1'b0);
    check("model_cnt5_sat", 32'(m_b[5]), 32'd3);
    do_upd(5, 1'b0, 1'b0); #1;
    check("idx5_1nt", {31'd0, bp_b}, 32'd1);
    do_upd(5, 1'b0, 1'b0); #1;
    check("idx5_2nt", {31'd0, bp_b}, 32'd0);

    // Target wrap cases.
    pc = 32'h0000_0000; inst = 32'h1000_FFFF; #1;
    check("addr_neg1", addr_b, 32'h0000_0000);
    pc = 32'h0000_0004; inst = 32'h1000_8000; #1;
    check("addr_wrap", addr_b, 32'hFFFE_0008);

    // Same-cycle lookup and update on index 2.
    pc = 32'h0000_0008; inst = 32'h1000_0000;
    upd_valid = 1'b1; upd_index = 6'd2; upd_taken = 1'b1; #1;
    check("bypass_same", {31'd0, bp_b}, 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0; #1;
    check("bypass_next", {31'd0, bp_b}, 32'd1);

    // Fill the gshare history with taken outcomes.
    for (int k = 0; k < 4; k++) do_upd(40, 1'b1, 1'b0);
    pc = 32'h0000_0000; #1;
    check("model_ghr", 32'(m_ghr), 32'd15);
    check("gsh_index_f", {26'd0, idx_g}, 32'h0000_000F);
    check("bim_index_0", {26'd0, idx_b}, 32'd0);

    // Five mispredictions: bimodal counts, gshare saturates at 3.
    for (int k = 0; k < 5; k++) do_upd(40, 1'b1, 1'b1);
    check("mis_bim5", mis_b, 32'd5);
    check("mis_gsh_sat", {30'd0, mis_g}, 32'd3);
    pc = 32'h0000_00A0; inst = 32'h1000_0000; #1;
    check("idx40_pred", {31'd0, bp_b}, 32'd1);
    inst = 32'h0000_0000; #1;
    check("nonbranch", {31'd0, bp_b}, 32'd0);
    inst = 32'h0401_0000; #1;
    check("bgez_pred", {31'd0, bp_b}, 32'd1);
    inst = 32'h0402_0000; #1;
    check("regimm_other", {31'd0, bp_b}, 32'd0);
    inst = 32'h1000_0000; #1;

    // Mid-cycle asynchronous reset.
    rst = 1'b0; #1;
    check("async_mis_gsh", {30'd0, mis_g}, 32'd0);
    check("async_mis_bim", mis_b, 32'd0);
    check("async_pred", {31'd0, bp_b}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      pc = $urandom;
      if ($urandom_range(0, 3) == 0) inst = $urandom;
      else inst = br_ops[$urandom_range(0, 7)] | ($urandom & 32'h03E0_FFFF);
      upd_valid      = ($urandom_range(0, 2) != 0);
      upd_index      = 6'($urandom_range(0, 15));
      pc[7:2]        = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 15)) : pc[7:2];
      upd_taken      = $urandom_range(0, 1) == 1;
      upd_mispredict = $urandom_range(0, 1) == 1;
      rst            = ($urandom_range(0, 60) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; upd_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
